processor_nic: RTL and testbench

- Network interface between the four-stage processor's data-memory port and the local mesh router port.
- The processor sees four 64-bit memory-mapped registers: input buffer, input status, output buffer, output status.
- The router side uses a valid/ready handshake with one-entry buffers in each direction.
- An output packet is injected only when its VC bit matches the router's current polarity.

---
 rtl/nic_pkg.sv | 21 ++
 rtl/nic_channel_buffer.sv | 45 ++++
 rtl/processor_nic.sv | 118 +++++++++++
 tb/tb_processor_nic.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
// ============================================================================
// Module   : nic_pkg
// Purpose  : Shared register map and bit positions for processor_nic.
// Revision : 1.0
// ============================================================================
`default_nettype none

package nic_pkg;

  localparam logic [1:0] NIC_IN_BUF     = 2'b00;
  localparam logic [1:0] NIC_IN_STATUS  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF    = 2'b10;
  localparam logic [1:0] NIC_OUT_STATUS = 2'b11;

  localparam int NIC_VC_BIT_DEFAULT = 0;
  // Big-endian numbering: bit 63 is the LSB of a 64-bit status word.
  localparam int NIC_STATUS_BIT     = 63;

endpackage

`default_nettype wire

// File: rtl/nic_channel_buffer.sv
// ============================================================================
// Module   : nic_channel_buffer
// Purpose  : One-entry data register with full flag; a push is ignored while full.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nic_channel_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [0:WIDTH-1] i_data,
  output logic [0:WIDTH-1] o_data,
  output logic             o_full
);

  logic [0:WIDTH-1] r_data;
  logic             r_full;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && r_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_data <= i_data;
      end
      r_full <= (r_full && !w_pop_ok) || w_push_ok;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/processor_nic.sv
// ============================================================================
// Module   : processor_nic
// Purpose  : Memory-mapped NIC between processor data port and mesh router.
//            Optional macro NIC_IRQ_EN adds a registered irq_out port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module processor_nic
  import nic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2,
  parameter int VC_BIT     = NIC_VC_BIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:ADDR_WIDTH-1] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity,
  input  logic                  net_si,
  output logic                  net_ri,
`ifdef NIC_IRQ_EN
  output logic                  irq_out,
`endif
  input  logic [0:DATA_WIDTH-1] net_di
);

  localparam int c_STATUS_BIT = (DATA_WIDTH == 64) ? NIC_STATUS_BIT : DATA_WIDTH - 1;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_in_pop;
  logic                  w_out_push;
  logic                  w_in_full;
  logic                  w_out_full;
  logic [0:DATA_WIDTH-1] w_in_data;
  logic [0:DATA_WIDTH-1] w_out_data;
  logic [0:DATA_WIDTH-1] w_in_status;
  logic [0:DATA_WIDTH-1] w_out_status;
  logic [0:DATA_WIDTH-1] r_d_out;

  assign w_rd       = nicEn && !nicWrEn;
  assign w_wr       = nicEn && nicWrEn;
  assign w_in_pop   = w_rd && (addr == NIC_IN_BUF);
  assign w_out_push = w_wr && (addr == NIC_OUT_BUF);

  nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_in_chan (
    .clk    (clk),
    .reset  (reset),
    .i_push (net_si),
    .i_pop  (w_in_pop),
    .i_data (net_di),
    .o_data (w_in_data),
    .o_full (w_in_full)
  );

  // A send completing this edge still sees full, so a same-cycle write is dropped.
  nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_out_chan (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_out_push),
    .i_pop  (net_so),
    .i_data (d_in),
    .o_data (w_out_data),
    .o_full (w_out_full)
  );

  assign net_ri = !w_in_full;
  assign net_do = w_out_data;
  assign net_so = w_out_full && net_ro && (w_out_data[VC_BIT] == net_polarity);

  always_comb begin
    w_in_status               = '0;
    w_out_status              = '0;
    w_in_status[c_STATUS_BIT]  = w_in_full;
    w_out_status[c_STATUS_BIT] = w_out_full;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_d_out <= '0;
    end else if (w_rd) begin
      case (addr)
        NIC_IN_BUF:     r_d_out <= w_in_data;
        NIC_IN_STATUS:  r_d_out <= w_in_status;
        NIC_OUT_BUF:    r_d_out <= w_out_data;
        NIC_OUT_STATUS: r_d_out <= w_out_status;
      endcase
    end
  end

  assign d_out = r_d_out;

`ifdef NIC_IRQ_EN
  logic r_irq;

  // Tracks the input flag's next value so it rises with the accept and falls after the read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= (w_in_full && !w_in_pop) || (net_si && !w_in_full);
    end
  end

  assign irq_out = r_irq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_processor_nic.sv
// ============================================================================
// Module   : tb_processor_nic
// Purpose  : Table-driven self-checking bench for processor_nic (NIC_IRQ_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_processor_nic;

  localparam logic [63:0] c_A = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] c_P = 64'h8000_0000_0000_00FF;
  localparam logic [63:0] c_B = 64'h0000_0000_0000_BEEF;
  localparam logic [63:0] c_W = 64'h0000_0000_0000_1234;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
`ifdef NIC_IRQ_EN
  logic        irq_out;
`endif

  int total = 0;
  int bad   = 0;

  processor_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
`ifdef NIC_IRQ_EN
    .irq_out      (irq_out),
`endif
    .net_di       (net_di)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        wr;
    logic [1:0]  a;
    logic [63:0] din;
    logic        ro;
    logic        pol;
    logic        si;
    logic [63:0] di;
    logic [63:0] e_dout;
    logic        e_so;
    logic        e_ri;
    logic [63:0] e_do;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic en, logic wr, logic [1:0] a, logic [63:0] din,
                              logic ro, logic pol, logic si, logic [63:0] di,
                              logic [63:0] e_dout, logic e_so, logic e_ri, logic [63:0] e_do);
    vec_t v;
    v.rst = rst; v.en = en; v.wr = wr; v.a = a; v.din = din;
    v.ro = ro; v.pol = pol; v.si = si; v.di = di;
    v.e_dout = e_dout; v.e_so = e_so; v.e_ri = e_ri; v.e_do = e_do;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; nicEn = v.en; nicWrEn = v.wr; addr = v.a; d_in = v.din;
    net_ro = v.ro; net_polarity = v.pol; net_si = v.si; net_di = v.di;
  endtask

  task automatic idle();
    drive(mk(1, 0, 0, 2'b00, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0));
  endtask

  initial begin
    bit seen;
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    //        rst en wr addr   din  ro pol si di     e_dout e_so e_ri e_do
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 0, 0,    0,    0, 1, 0));    // 0 reset state
    tbl.push_back(mk(1, 1, 0, 2'b01, 0,   0, 0, 0, 0,    0,    0, 1, 0));    // 1 read in_status
    tbl.push_back(mk(1, 1, 0, 2'b11, 0,   0, 0, 0, 0,    0,    0, 1, 0));    // 2 read out_status
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 1, c_A,  0,    0, 1, 0));    // 3 packet A arrives
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 0, 0,    0,    0, 0, 0));    // 4
    tbl.push_back(mk(1, 1, 0, 2'b01, 0,   0, 0, 0, 0,    0,    0, 0, 0));    // 5 read in_status
    tbl.push_back(mk(1, 1, 0, 2'b00, 0,   0, 0, 0, 0,    1,    0, 0, 0));    // 6 read in_buf
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 0, 0,    c_A,  0, 1, 0));    // 7
    tbl.push_back(mk(1, 1, 1, 2'b10, c_P, 1, 0, 0, 0,    c_A,  0, 1, 0));    // 8 write P
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   1, 0, 0, 0,    c_A,  0, 1, c_P));  // 9 VC mismatch
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   1, 1, 0, 0,    c_A,  1, 1, c_P));  // 10 polarity match
    tbl.push_back(mk(1, 1, 0, 2'b11, 0,   1, 1, 0, 0,    c_A,  0, 1, c_P));  // 11 sent once
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 0, 0,    0,    0, 1, c_P));  // 12 out_status 0
    tbl.push_back(mk(1, 1, 1, 2'b10, c_P, 0, 0, 0, 0,    0,    0, 1, c_P));  // 13 write P
    tbl.push_back(mk(1, 1, 1, 2'b10, c_W, 0, 1, 0, 0,    0,    0, 1, c_P));  // 14 write while full
    tbl.push_back(mk(1, 1, 0, 2'b10, 0,   0, 0, 0, 0,    0,    0, 1, c_P));  // 15 read out_buf
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 0, 0,    c_P,  0, 1, c_P));  // 16
    tbl.push_back(mk(1, 1, 1, 2'b10, c_W, 1, 1, 0, 0,    c_P,  1, 1, c_P));  // 17 write in send cycle
    tbl.push_back(mk(1, 1, 0, 2'b11, 0,   1, 1, 0, 0,    c_P,  0, 1, c_P));  // 18
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 0, 0,    0,    0, 1, c_P));  // 19
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 1, c_A,  0,    0, 1, c_P));  // 20 A arrives
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 1, c_B,  0,    0, 0, c_P));  // 21 B held
    tbl.push_back(mk(1, 1, 0, 2'b00, 0,   0, 0, 1, c_B,  0,    0, 0, c_P));  // 22 read A, B still held
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 1, c_B,  c_A,  0, 1, c_P));  // 23 B accepted
    tbl.push_back(mk(1, 1, 0, 2'b00, 0,   0, 0, 0, 0,    c_A,  0, 0, c_P));  // 24 read B
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 0, 0,    c_B,  0, 1, c_P));  // 25
    tbl.push_back(mk(1, 1, 0, 2'b00, 0,   0, 0, 0, 0,    c_B,  0, 1, c_P));  // 26 read empty
    tbl.push_back(mk(1, 1, 0, 2'b01, 0,   0, 0, 0, 0,    c_B,  0, 1, c_P));  // 27 stale data
    tbl.push_back(mk(1, 0, 1, 2'b10, c_W, 0, 0, 0, 0,    0,    0, 1, c_P));  // 28 nicEn=0 write
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   1, 0, 0, 0,    0,    0, 1, c_P));  // 29 nothing pending
    tbl.push_back(mk(1, 1, 1, 2'b10, c_B, 0, 0, 0, 0,    0,    0, 1, c_P));  // 30 write B
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   0, 0, 1, c_A,  0,    0, 1, c_B));  // 31 A arrives
    tbl.push_back(mk(0, 1, 0, 2'b00, 0,   0, 0, 0, 0,    0,    0, 0, c_B));  // 32 reset mid-transfer
    tbl.push_back(mk(1, 0, 0, 2'b00, 0,   1, 0, 0, 0,    0,    0, 1, 0));    // 33 all cleared

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_dout", i), d_out, tbl[i].e_dout);
      chk($sformatf("v%0d_so", i), {63'b0, net_so}, {63'b0, tbl[i].e_so});
      chk($sformatf("v%0d_ri", i), {63'b0, net_ri}, {63'b0, tbl[i].e_ri});
      chk($sformatf("v%0d_do", i), net_do, tbl[i].e_do);
`ifdef NIC_IRQ_EN
      // irq_out mirrors the input-full flag one edge after the change that sets/clears it
      if (i > 0)
        chk($sformatf("v%0d_irq", i), {63'b0, irq_out}, {63'b0, !tbl[i].e_ri});
`endif
      @(negedge clk);
    end

    // Packet with VC bit 0 waits while polarity is 1, then leaves once it toggles
    drive(mk(1, 1, 1, 2'b10, c_B, 1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drive(mk(1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      #1;
      chk($sformatf("vcwait%0d_so", k), {63'b0, net_so}, 64'h0);
      chk($sformatf("vcwait%0d_do", k), net_do, c_B);
      @(negedge clk);
    end
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      drive(mk(1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      #1;
      if (net_so) seen = 1'b1;
      @(negedge clk);
    end
    chk("vcwait_send_seen", {63'b0, seen}, 64'h1);
    drive(mk(1, 1, 0, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    idle();
    #1;
    chk("vcwait_out_status", d_out, 64'h0);
    chk("vcwait_so_after", {63'b0, net_so}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
